// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI3-style read/write channels (no burst/lock/cache/prot) between a master and the SRAM slave.
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  modport slave (
    input  arid, araddr, arlen, arsize, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
  modport master (
    output arid, araddr, arlen, arsize, arvalid, rready,
    output awid, awaddr, awlen, awsize, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-port synchronous SRAM behind an AXI slave, one transaction at a time, INCR bursts only.
module axi_sram_slave #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic           clk,
  input logic           resetn,
  axi_sram_slave_if.slave s
);
  typedef enum logic [2:0] {IDLE, RD_ACC, RD_RESP, WR_DATA, WR_RESP} state_t;
  state_t r_state, w_next;
  logic                  r_up;
  logic [3:0]            r_id;
  logic [29:0]           r_addr;
  logic [7:0]            r_cnt;
  logic                  r_err;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;
  logic [31:0]           r_mem [2**DEPTH_LOG2];
  logic [31:0]           w_off;
  logic                  w_in;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_aw, w_ar, w_r, w_w;
  logic                  w_unused;
  // Per-beat range check: offset from BASE_ADDR must fit in the RAM, wrap included.
  assign w_off    = {r_addr, 2'b00} - BASE_ADDR;
  assign w_in     = w_off[31:DEPTH_LOG2+2] == '0;
  assign w_idx    = w_off[DEPTH_LOG2+1:2];
  assign w_aw     = s.awvalid && s.awready;
  assign w_ar     = s.arvalid && s.arready;
  assign w_r      = s.rvalid && s.rready;
  assign w_w      = s.wvalid && s.wready;
  assign w_unused = ^{s.arsize, s.awsize, s.wid, s.araddr[1:0], s.awaddr[1:0], w_off[1:0]};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_aw ? WR_DATA : w_ar ? RD_ACC : IDLE;
      RD_ACC:  w_next = RD_RESP;
      RD_RESP: w_next = !w_r ? RD_RESP : r_cnt == 8'd0 ? IDLE : RD_ACC;
      WR_DATA: w_next = w_w && (s.wlast || r_cnt == 8'd0) ? WR_RESP : WR_DATA;
      WR_RESP: w_next = s.bready ? IDLE : WR_RESP;
      default: w_next = IDLE;
    endcase
  end
  // r_up keeps both address channels closed until the first edge after reset.
  always_comb begin
    s.awready = r_up && r_state == IDLE;
    s.arready = r_up && r_state == IDLE && !s.awvalid;
    s.rvalid  = r_state == RD_RESP;
    s.rlast   = r_state == RD_RESP && r_cnt == 8'd0;
    s.wready  = r_state == WR_DATA;
    s.bvalid  = r_state == WR_RESP;
    s.rid     = r_id;
    s.bid     = r_id;
    s.rdata   = r_rdata;
    s.rresp   = r_rresp;
    s.bresp   = r_err ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_up    <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else begin
      r_up <= 1'b1;
      if (w_aw) begin
        r_id   <= s.awid;
        r_addr <= s.awaddr[31:2];
        r_cnt  <= s.awlen;
        r_err  <= 1'b0;
      end else if (w_ar) begin
        r_id   <= s.arid;
        r_addr <= s.araddr[31:2];
        r_cnt  <= s.arlen;
      end else if (r_state == RD_ACC) begin
        r_rdata <= w_in ? r_mem[w_idx] : '0;
        r_rresp <= w_in ? 2'b00 : 2'b10;
      end else if (w_r || w_w) begin
        r_addr <= r_addr + 30'd1;
        r_cnt  <= r_cnt - 8'd1;
        r_err  <= r_err | (w_w && !w_in);
      end
    end
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (w_w && w_in && s.wstrb[b]) r_mem[w_idx][8*b +: 8] <= s.wdata[8*b +: 8];
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed scenario tasks with hand-computed expectations for axi_sram_slave.
module tb_axi_sram_slave;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  axi_sram_slave_if bus();
  axi_sram_slave dut (.clk(clk), .resetn(resetn), .s(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    bus.awaddr = a; bus.awlen = len; bus.awid = id; bus.awsize = 3'd2; bus.awvalid = 1'b1;
    #1;
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    if (!bus.awready) begin checks++; errors++; $display("FAIL aw_timeout got awready=0 want 1"); end
    @(posedge clk); #1 bus.awvalid = 1'b0;
  endtask
  task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    bus.araddr = a; bus.arlen = len; bus.arid = id; bus.arsize = 3'd2; bus.arvalid = 1'b1;
    #1;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    if (!bus.arready) begin checks++; errors++; $display("FAIL ar_timeout got arready=0 want 1"); end
    @(posedge clk); #1 bus.arvalid = 1'b0;
  endtask
  task automatic do_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.wdata = d; bus.wstrb = strb; bus.wlast = last; bus.wid = 4'hF; bus.wvalid = 1'b1;
    #1;
    while (!bus.wready && n < 50) begin @(negedge clk); n++; end
    if (!bus.wready) begin checks++; errors++; $display("FAIL w_timeout got wready=0 want 1"); end
    @(posedge clk); #1 bus.wvalid = 1'b0;
  endtask
  task automatic do_b(output logic [3:0] id, output logic [1:0] resp);
    int n = 0;
    bus.bready = 1'b1;
    #1;
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.bvalid) begin checks++; errors++; $display("FAIL b_timeout got bvalid=0 want 1"); end
    id = bus.bid; resp = bus.bresp;
    @(posedge clk); #1 bus.bready = 1'b0;
  endtask
  task automatic do_r(output logic [31:0] d, output logic [1:0] resp, output logic last, output logic [3:0] id);
    int n = 0;
    bus.rready = 1'b1;
    #1;
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.rvalid) begin checks++; errors++; $display("FAIL r_timeout got rvalid=0 want 1"); end
    d = bus.rdata; resp = bus.rresp; last = bus.rlast; id = bus.rid;
    @(posedge clk); #1 bus.rready = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    checks++; if ({bus.arready, bus.rvalid, bus.rlast, bus.wready, bus.bvalid} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b want 00000", {bus.arready, bus.rvalid, bus.rlast, bus.wready, bus.bvalid}); end
    checks++; if ({bus.rid, bus.bid, bus.rresp, bus.bresp, bus.rdata} !== 44'h0) begin errors++; $display("FAIL reset_data got %h want 0", {bus.rid, bus.bid, bus.rresp, bus.bresp, bus.rdata}); end
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.arready, bus.awready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", {bus.arready, bus.awready}); end
  endtask
  task automatic test_basic();
    logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;
    do_aw(32'h10, 8'd0, 4'd3);
    do_w(32'hDEADBEEF, 4'hF, 1'b1);
    @(negedge clk);
    checks++; if ({bus.bvalid, bus.bid, bus.bresp, bus.wready} !== {1'b1, 4'd3, 2'b00, 1'b0}) begin errors++; $display("FAIL basic_b got v=%b id=%0d resp=%b wready=%b want 1 3 00 0", bus.bvalid, bus.bid, bus.bresp, bus.wready); end
    do_b(id, resp);
    do_ar(32'h10, 8'd0, 4'd5);
    @(negedge clk);
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL basic_rlat1 got rvalid=%b want 0", bus.rvalid); end
    @(negedge clk);
    checks++; if ({bus.rvalid, bus.rdata, bus.rid, bus.rlast, bus.rresp} !== {1'b1, 32'hDEADBEEF, 4'd5, 1'b1, 2'b00}) begin errors++; $display("FAIL basic_r got v=%b d=%h id=%0d last=%b resp=%b want 1 deadbeef 5 1 00", bus.rvalid, bus.rdata, bus.rid, bus.rlast, bus.rresp); end
    do_r(d, resp, last, id);
  endtask
  task automatic test_strobe();
    logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;
    do_aw(32'h20, 8'd0, 4'd1); do_w(32'h11223344, 4'hF, 1'b1); do_b(id, resp);
    do_aw(32'h22, 8'd0, 4'd1); do_w(32'h0000AA00, 4'b0010, 1'b1); do_b(id, resp);
    do_ar(32'h20, 8'd0, 4'd2); do_r(d, resp, last, id);
    checks++; if ({d, resp, last} !== {32'h1122AA44, 2'b00, 1'b1}) begin errors++; $display("FAIL strobe got d=%h resp=%b last=%b want 1122aa44 00 1", d, resp, last); end
  endtask
  task automatic test_burst_stall();
    logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;
    int n;
    do_aw(32'h100, 8'd3, 4'd2);
    for (int i = 0; i < 4; i++) do_w(32'hB000_0100 + 32'(i), 4'hF, i == 3);
    do_b(id, resp);
    checks++; if ({id, resp} !== {4'd2, 2'b00}) begin errors++; $display("FAIL burst_b got id=%0d resp=%b want 2 00", id, resp); end
    do_ar(32'h100, 8'd3, 4'd7);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        n = 0;
        while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++; if ({bus.rvalid, bus.rdata, bus.rlast} !== {1'b1, 32'hB000_0101, 1'b0}) begin errors++; $display("FAIL stall_hold%0d got v=%b d=%h last=%b want 1 b0000101 0", k, bus.rvalid, bus.rdata, bus.rlast); end
        end
      end
      do_r(d, resp, last, id);
      checks++; if ({d, resp, last, id} !== {32'hB000_0100 + 32'(i), 2'b00, i == 3, 4'd7}) begin errors++; $display("FAIL burst_beat%0d got d=%h resp=%b last=%b id=%0d want %h 00 %0d 7", i, d, resp, last, id, 32'hB000_0100 + 32'(i), i == 3); end
    end
  endtask
  task automatic test_collision();
    logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;
    bus.awaddr = 32'h30; bus.awlen = 8'd0; bus.awid = 4'd4; bus.awvalid = 1'b1;
    bus.araddr = 32'h20; bus.arlen = 8'd0; bus.arid = 4'd6; bus.arvalid = 1'b1;
    #1;
    checks++; if ({bus.awready, bus.arready} !== 2'b10) begin errors++; $display("FAIL coll_ready got aw=%b ar=%b want 1 0", bus.awready, bus.arready); end
    @(posedge clk); #1 bus.awvalid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.wready, bus.arready} !== 2'b10) begin errors++; $display("FAIL coll_wr got wready=%b arready=%b want 1 0", bus.wready, bus.arready); end
    do_w(32'h5555AAAA, 4'hF, 1'b1); do_b(id, resp);
    checks++; if ({id, resp} !== {4'd4, 2'b00}) begin errors++; $display("FAIL coll_b got id=%0d resp=%b want 4 00", id, resp); end
    do_ar(32'h20, 8'd0, 4'd6); do_r(d, resp, last, id);
    checks++; if ({d, id} !== {32'h1122AA44, 4'd6}) begin errors++; $display("FAIL coll_r got d=%h id=%0d want 1122aa44 6", d, id); end
  endtask
  task automatic test_top();
    logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;
    do_aw(32'h0, 8'd0, 4'd1); do_w(32'h0BADC0DE, 4'hF, 1'b1); do_b(id, resp);
    do_aw(32'hFFC, 8'd1, 4'd8); do_w(32'h13579BDF, 4'hF, 1'b0); do_w(32'h2468ACE0, 4'hF, 1'b1); do_b(id, resp);
    checks++; if ({id, resp} !== {4'd8, 2'b10}) begin errors++; $display("FAIL top_b got id=%0d resp=%b want 8 10", id, resp); end
    do_ar(32'hFFC, 8'd1, 4'd9);
    do_r(d, resp, last, id);
    checks++; if ({d, resp, last} !== {32'h13579BDF, 2'b00, 1'b0}) begin errors++; $display("FAIL top_r0 got d=%h resp=%b last=%b want 13579bdf 00 0", d, resp, last); end
    do_r(d, resp, last, id);
    checks++; if ({d, resp, last} !== {32'h0, 2'b10, 1'b1}) begin errors++; $display("FAIL top_r1 got d=%h resp=%b last=%b want 0 10 1", d, resp, last); end
    do_ar(32'h0, 8'd0, 4'd1); do_r(d, resp, last, id);
    checks++; if (d !== 32'h0BADC0DE) begin errors++; $display("FAIL top_nowrap got d=%h want 0badc0de", d); end
    do_aw(32'h40, 8'd0, 4'd2); do_w(32'h1, 4'hF, 1'b1); do_b(id, resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL top_errclr got resp=%b want 00", resp); end
  endtask
  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;
    int n = 0;
    do_ar(32'h10, 8'd0, 4'd9);
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
    #2 resetn = 1'b0;
    #1;
    checks++; if ({bus.rvalid, bus.rid, bus.rdata, bus.arready} !== 38'h0) begin errors++; $display("FAIL midrst got v=%b id=%0d d=%h arready=%b want 0 0 0 0", bus.rvalid, bus.rid, bus.rdata, bus.arready); end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    do_ar(32'h10, 8'd0, 4'd10); do_r(d, resp, last, id);
    checks++; if ({d, resp, last, id} !== {32'hDEADBEEF, 2'b00, 1'b1, 4'd10}) begin errors++; $display("FAIL midrst_r got d=%h resp=%b last=%b id=%0d want deadbeef 00 1 10", d, resp, last, id); end
    do_ar(32'h104, 8'd0, 4'd1); do_r(d, resp, last, id);
    checks++; if (d !== 32'hB000_0101) begin errors++; $display("FAIL midrst_ram got d=%h want b0000101", d); end
  endtask
  initial begin
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    test_reset();
    test_basic();
    test_strobe();
    test_burst_stall();
    test_collision();
    test_top();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
